// File: rtl/polaris_pkg.sv
// Shared definitions for the operand-fetch / ALU slice.
package polaris_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;

  typedef enum logic [1:0] {
    SELA_RS1  = 2'd0,
    SELA_PC   = 2'd1,
    SELA_ZERO = 2'd2,
    SELA_RSVD = 2'd3
  } selA_e;

  typedef enum logic [1:0] {
    SELB_RS2  = 2'd0,
    SELB_IMM  = 2'd1,
    SELB_FOUR = 2'd2,
    SELB_RSVD = 2'd3
  } selB_e;

endpackage

// File: rtl/operand_fetch_regfile.sv
// 32 x XLEN integer register file: x0 hardwired to zero, one synchronous
// write port, two combinational read ports with write-back bypass.
module regfile
  import polaris_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs1Idx,
  input  logic [REG_IDX_W-1:0] rs2Idx,
  output logic [XLEN-1:0]      rs1Dat,
  output logic [XLEN-1:0]      rs2Dat,
  input  logic                 wbWe,
  input  logic [REG_IDX_W-1:0] wbRd,
  input  logic [XLEN-1:0]      wbDat
);

  // x0 has no storage; reads of index 0 are forced to zero below.
  logic [XLEN-1:0] regs [1:NUM_REGS-1];

  // Write port; writes to x0 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wbWe && (wbRd != '0)) begin
      regs[wbRd] <= wbDat;
    end
  end

  // Read port 1 with same-cycle bypass from the write-back port.
  always_comb begin
    rs1Dat = '0;
    if (rs1Idx != '0) begin
      rs1Dat = (wbWe && (wbRd == rs1Idx)) ? wbDat : regs[rs1Idx];
    end
  end

  // Read port 2 with same-cycle bypass from the write-back port.
  always_comb begin
    rs2Dat = '0;
    if (rs2Idx != '0) begin
      rs2Dat = (wbWe && (wbRd == rs2Idx)) ? wbDat : regs[rs2Idx];
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register read, operand select and a registered
// valid/ready output stage feeding the ALU.
module operand_fetch
  import polaris_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  logic [REG_IDX_W-1:0] rs1_i,
  input  logic [REG_IDX_W-1:0] rs2_i,
  input  logic [REG_IDX_W-1:0] rd_i,
  input  logic [1:0]           selA_i,
  input  logic [1:0]           selB_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [XLEN-1:0]      imm_i,
  output logic                 alu_valid_o,
  input  logic                 alu_ready_i,
  output logic [XLEN-1:0]      inA_o,
  output logic [XLEN-1:0]      inB_o,
  output logic [REG_IDX_W-1:0] rd_o,
  input  logic                 wb_we_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]      wb_dat_i
);

  logic [XLEN-1:0] rs1Dat;
  logic [XLEN-1:0] rs2Dat;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic            accept;

  regfile uRegfile (
    .clk    (clk_i),
    .rst    (reset_i),
    .rs1Idx (rs1_i),
    .rs2Idx (rs2_i),
    .rs1Dat (rs1Dat),
    .rs2Dat (rs2Dat),
    .wbWe   (wb_we_i),
    .wbRd   (wb_rd_i),
    .wbDat  (wb_dat_i)
  );

  // Operand A select; zero and reserved codes both give 0.
  always_comb begin
    opA = '0;
    case (selA_e'(selA_i))
      SELA_RS1: opA = rs1Dat;
      SELA_PC:  opA = pc_i;
      default:  opA = '0;
    endcase
  end

  // Operand B select; reserved code gives 0.
  always_comb begin
    opB = '0;
    case (selB_e'(selB_i))
      SELB_RS2:  opB = rs2Dat;
      SELB_IMM:  opB = imm_i;
      SELB_FOUR: opB = XLEN'(4);
      default:   opB = '0;
    endcase
  end

  // Output slot is free when empty or being drained this cycle.
  always_comb begin
    dec_ready_o = !alu_valid_o || alu_ready_i;
    accept      = dec_valid_i && dec_ready_o;
  end

  // Output register: load on accept, drop valid on consume-without-refill.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      alu_valid_o <= 1'b0;
      inA_o       <= '0;
      inB_o       <= '0;
      rd_o        <= '0;
    end else if (accept) begin
      alu_valid_o <= 1'b1;
      inA_o       <= opA;
      inB_o       <= opB;
      rd_o        <= rd_i;
    end else if (alu_ready_i) begin
      alu_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: vector table with scoreboard,
// plus hand-written backpressure and asynchronous reset sequences.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        decValid;
  logic        decReady;
  logic [4:0]  rs1, rs2, rd;
  logic [1:0]  selA, selB;
  logic [63:0] pc, imm;
  logic        aluValid;
  logic        aluReady;
  logic [63:0] inA, inB;
  logic [4:0]  rdOut;
  logic        wbWe;
  logic [4:0]  wbRd;
  logic [63:0] wbDat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  selA, selB;
    logic [63:0] pc, imm;
    logic        wbWe;
    logic [4:0]  wbRd;
    logic [63:0] wbDat;
    logic [63:0] expA, expB;
  } vec_t;

  typedef struct {
    logic [63:0] a, b;
    logic [4:0]  rd;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  exp_t popped;

  localparam logic [63:0] X3VAL = 64'h1234_5678_9ABC_DEF0;

  operand_fetch dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .dec_valid_i (decValid),
    .dec_ready_o (decReady),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .rd_i        (rd),
    .selA_i      (selA),
    .selB_i      (selB),
    .pc_i        (pc),
    .imm_i       (imm),
    .alu_valid_o (aluValid),
    .alu_ready_i (aluReady),
    .inA_o       (inA),
    .inB_o       (inB),
    .rd_o        (rdOut),
    .wb_we_i     (wbWe),
    .wb_rd_i     (wbRd),
    .wb_dat_i    (wbDat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
    selA = v.selA; selB = v.selB;
    pc = v.pc; imm = v.imm;
    wbWe = v.wbWe; wbRd = v.wbRd; wbDat = v.wbDat;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard: compare every transfer the ALU side consumes.
  always @(negedge clk) begin
    if (!reset && aluValid && aluReady) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got A=0x%0h B=0x%0h with empty scoreboard", inA, inB);
      end else begin
        popped = sb.pop_front();
        chk("opA", inA, popped.a);
        chk("opB", inB, popped.b);
        chk("rd", 64'(rdOut), 64'(popped.rd));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // rs1 rs2 rd selA selB pc imm wbWe wbRd wbDat expA expB
    tbl.push_back(vec_t'{5'd5, 5'd7, 5'd1, 2'd0, 2'd0, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0});
    tbl.push_back(vec_t'{5'd1, 5'd2, 5'd2, 2'd0, 2'd0, 64'h0, 64'h0, 1'b1, 5'd3, X3VAL, 64'h0, 64'h0});
    tbl.push_back(vec_t'{5'd3, 5'd0, 5'd3, 2'd0, 2'd0, 64'h0, 64'h0, 1'b1, 5'd0, '1, X3VAL, 64'h0});
    tbl.push_back(vec_t'{5'd0, 5'd3, 5'd4, 2'd0, 2'd0, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h0, X3VAL});
    tbl.push_back(vec_t'{5'd9, 5'd9, 5'd5, 2'd0, 2'd0, 64'h0, 64'h0, 1'b1, 5'd9, 64'h42, 64'h42, 64'h42});
    tbl.push_back(vec_t'{5'd9, 5'd3, 5'd6, 2'd0, 2'd0, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h42, X3VAL});
    tbl.push_back(vec_t'{5'd3, 5'd3, 5'd7, 2'd1, 2'd1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 5'd0, 64'h0,
                         64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFF0});
    tbl.push_back(vec_t'{5'd3, 5'd3, 5'd8, 2'd2, 2'd2, 64'h55, 64'h66, 1'b0, 5'd0, 64'h0, 64'h0, 64'h4});
    tbl.push_back(vec_t'{5'd3, 5'd3, 5'd9, 2'd3, 2'd3, 64'h55, 64'h66, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0});
    tbl.push_back(vec_t'{5'd3, 5'd4, 5'd10, 2'd0, 2'd0, 64'h0, 64'h0, 1'b1, 5'd4, 64'hDEAD, X3VAL, 64'hDEAD});
    tbl.push_back(vec_t'{5'd5, 5'd4, 5'd31, 2'd0, 2'd1, 64'h0, 64'h10, 1'b1, 5'd5, 64'h77, 64'h77, 64'h10});

    reset = 1'b1; decValid = 1'b0; aluReady = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; selA = '0; selB = '0; pc = '0; imm = '0;
    wbWe = 1'b0; wbRd = '0; wbDat = '0;

    // Reset state.
    #12;
    chk("rst_valid", 64'(aluValid), 64'd0);
    chk("rst_inA", inA, 64'd0);
    chk("rst_inB", inB, 64'd0);
    chk("rst_rd", 64'(rdOut), 64'd0);
    chk("rst_ready", 64'(decReady), 64'd1);
    #10 reset = 1'b0;

    // Table phase: one instruction per cycle with the ALU always ready.
    @(posedge clk); #1;
    aluReady = 1'b1;
    decValid = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(exp_t'{tbl[i].expA, tbl[i].expB, tbl[i].rd});
      @(posedge clk); #1;
      chk("latency_valid", 64'(aluValid), 64'd1);
    end
    decValid = 1'b0; wbWe = 1'b0;
    drain("table_drain");

    // Backpressure: P accepted, then Q held off for three cycles.
    @(posedge clk); #1;
    aluReady = 1'b0;
    decValid = 1'b1;
    v = vec_t'{5'd0, 5'd0, 5'd7, 2'd1, 2'd2, 64'h111, 64'h0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0};
    drive(v);
    sb.push_back(exp_t'{64'h111, 64'h4, 5'd7});
    @(posedge clk); #1;
    v = vec_t'{5'd0, 5'd0, 5'd8, 2'd1, 2'd1, 64'h222, 64'h333, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0};
    drive(v);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_ready", 64'(decReady), 64'd0);
      chk("bp_valid", 64'(aluValid), 64'd1);
      chk("bp_inA", inA, 64'h111);
      chk("bp_inB", inB, 64'h4);
      chk("bp_rd", 64'(rdOut), 64'd7);
      @(posedge clk); #1;
    end
    aluReady = 1'b1;
    sb.push_back(exp_t'{64'h222, 64'h333, 5'd8});
    @(posedge clk); #1;
    chk("bp_valid_stays", 64'(aluValid), 64'd1);
    decValid = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", 64'(aluValid), 64'd0);
    chk("idle_holdA", inA, 64'h222);
    chk("idle_holdB", inB, 64'h333);
    drain("bp_drain");

    // Asynchronous reset while a transfer is stalled at the output.
    @(posedge clk); #1;
    aluReady = 1'b0;
    decValid = 1'b1;
    v = vec_t'{5'd3, 5'd0, 5'd9, 2'd0, 2'd2, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0};
    drive(v);
    @(posedge clk); #1;
    decValid = 1'b0;
    chk("pre_rst_valid", 64'(aluValid), 64'd1);
    chk("pre_rst_inA", inA, X3VAL);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(aluValid), 64'd0);
    chk("arst_inA", inA, 64'd0);
    chk("arst_inB", inB, 64'd0);
    chk("arst_rd", 64'(rdOut), 64'd0);
    chk("arst_ready", 64'(decReady), 64'd1);
    #2 reset = 1'b0;

    // Register file was cleared by the reset.
    @(posedge clk); #1;
    aluReady = 1'b1;
    decValid = 1'b1;
    v = vec_t'{5'd3, 5'd9, 5'd12, 2'd0, 2'd0, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0};
    drive(v);
    sb.push_back(exp_t'{64'h0, 64'h0, 5'd12});
    @(posedge clk); #1;
    decValid = 1'b0;
    drain("post_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
